video_render_mx: RTL
====================

# video_render_mx

Parametrised, pipelined successor to the TSConf pixel renderer. It decodes the graphics-plane pixel (ZX, 16c, 256c, text) from fetched video data. It merges that pixel with border and a configurable number of TS layers under a programmable priority slot. It outputs the 8-bit video plex word to the palette stage. Sits between the video fetch/TS-render blocks and the palette/DAC path.

## Interface

Parameters:
- LAYERS, 2, number of TS layers (1..4); layer 0 has highest priority among TS layers.
- TRANS_BITS, 4, low bits of a TS pixel tested for transparency (all-zero = transparent).
- GPW, 2, width of gfx_pos; must satisfy 2^GPW >= LAYERS+1.

Ports:
- clk  in  1  system clock.
- res  in  1  reset, asynchronous, active-high.
- c1  in  1  pixel strobe; all state advances only on clk edges with c1=1.
- hvpix  in  1  active graphics window.
- hvtspix  in  1  active TS window.
- nogfx  in  1  graphics plane disabled.
- tsu_off  in  LAYERS  per-layer TS disable.
- gfx_pos  in  GPW  graphics-plane priority slot: 0 = above all layers, k = below layers 0..k-1, values >= LAYERS = below all.
- flash  in  1  ZX flash phase.
- hires  in  1  hi-res: plex carries two 4-bit pixels.
- psel  in  4  pixel select within data word.
- palsel  in  4  palette select for ZX/16c/text.
- render_mode  in  2  0 ZX, 1 16c, 2 256c, 3 text.
- data  in  32  fetched video data.
- border_in  in  8  border colour.
- tsdata_in  in  8*LAYERS  TS pixels; layer k at bits [8k+7:8k].
- vplex_out  out  8  video plex word.

## Operation

- Stage 1 (decode, registered on c1): gfx pixel and gfx-valid bit:
  - ZX mode: dot = data[{psel[3],~psel[2:0]}]; attr = psel[3] ? data[31:24] : data[23:16]; inverted = dot ^ (flash & attr[7]); pix = {palsel, attr[6], inverted ? attr[2:0] : attr[5:3]}; valid = inverted.
  - Text mode: pix = {palsel, dot ? attr[3:0] : attr[7:4]}; valid = dot.
  - 16c mode: nibble by psel[1:0]: 0→data[7:4], 1→[3:0], 2→[15:12], 3→[11:8]; pix = {palsel, nibble}; valid = |nibble.
  - 256c mode: psel[0] selects data[7:0] / data[15:8]; valid = |byte.
  - Stage 1 also registers tsdata_in, tsu_off, border_in, hvpix, hvtspix, nogfx, gfx_pos, hires.
- Layer k is visible when tsdata[k][TRANS_BITS-1:0] != 0 and !tsu_off[k].
- Stage 2 (mix, registered on c1) produces video:
  - If hvpix: walk slots 0..LAYERS in priority order. The gfx plane occupies slot gfx_pos and competes only when valid and !nogfx. The first visible candidate wins.
  - If nothing wins and nogfx=0, the output is the gfx pixel (even when transparent), matching ZX paper behaviour.
  - If nothing wins and nogfx=1, the output is border_in.
  - If !hvpix && hvtspix: the highest-priority visible layer, else border.
  - Otherwise: border.
- Hi-res packing: temp register captures video[3:0] on each c1. Output is hires_q ? {temp, video[3:0]} : video.

## Timing

- Reset: all pipeline registers, temp and vplex_out = 8'h00 immediately on res; they hold 0 until the second c1 after res deasserts.
- Latency: inputs sampled at c1 strobe n drive vplex_out after strobe n+1, i.e. 2 strobes. vplex_out changes only on clk edges with c1=1.
- c1=0: everything holds, including temp.
- hires toggling takes effect with the same 2-strobe latency as data. The first hires output after a toggle pairs with temp from the previous pixel, whatever its mode.
- gfx_pos out of range (>= LAYERS) is treated as LAYERS.
- Reset mid-frame: pipeline flushes to 0, no partial-pixel artefacts are held.

## Configuration

- RENDER_MX_HIRES_EN defined: hires packing and the temp register are present, as described above.
- Not defined: the hires input is ignored, temp is not instantiated, and vplex_out = video.

## Test plan

- Reset: assert res with c1 running → vplex_out=00. Release, present 256c data=16'hAB00, psel=1, hvpix=1, render_mode=2 → vplex_out=AB exactly 2 c1 strobes later.
- ZX flash: data[7]=1 (psel=0), attr=8'h8A (ink 2, paper 1, flash), palsel=3.
  - flash=0 → vplex_out=8'h32.
  - flash=1 → 8'h31.
- Priority: LAYERS=2, tsdata={8'h25,8'h13}, 16c gfx nibble 7, palsel=0.
  - gfx_pos=0 → 07.
  - gfx_pos=1 → 13.
  - gfx_pos=2 → 13.
  - tsu_off=01, gfx_pos=2 → 25.
- Transparency: tsdata all-zero low nibble, nogfx=1, border_in=8'hE5, hvpix=1 → E5. Then hvpix=0, hvtspix=1, layer1=8'h41 → 41.
- Hi-res (macro on): hires=1 with successive pixels 0x0C, 0x07 → second output 8'hC7. Hold c1=0 for 3 clocks → output unchanged.
- Macro off: hires=1, pixel 8'h5A → vplex_out=5A.

Source files
------------

// File: rtl/video_render_mx_if.sv
// video_render_mx_if -- pixel bus between fetch/TS-render and the renderer.
//   master : drives strobe, window flags, mode controls, video/TS data, border
//   slave  : the renderer; returns vplex_out (8-bit plex word to palette)
interface video_render_mx_if #(
  parameter int LAYERS = 2,
  parameter int GPW    = 2
) ();
  logic                  c1;
  logic                  hvpix;
  logic                  hvtspix;
  logic                  nogfx;
  logic [LAYERS-1:0]     tsu_off;
  logic [GPW-1:0]        gfx_pos;
  logic                  flash;
  logic                  hires;
  logic [3:0]            psel;
  logic [3:0]            palsel;
  logic [1:0]            render_mode;
  logic [31:0]           data;
  logic [7:0]            border_in;
  logic [8*LAYERS-1:0]   tsdata_in;
  logic [7:0]            vplex_out;

  modport master (
    output c1, hvpix, hvtspix, nogfx, tsu_off, gfx_pos, flash, hires,
           psel, palsel, render_mode, data, border_in, tsdata_in,
    input  vplex_out
  );
  modport slave (
    input  c1, hvpix, hvtspix, nogfx, tsu_off, gfx_pos, flash, hires,
           psel, palsel, render_mode, data, border_in, tsdata_in,
    output vplex_out
  );
endinterface

// File: rtl/video_render_mx.sv
// video_render_mx -- two-stage pixel renderer.
//   Stage 1 decodes the graphics-plane pixel (ZX / 16c / 256c / text) and
//   registers the TS pixels and controls; stage 2 merges gfx, TS layers and
//   border by priority slot and registers the plex word.
// Ports:
//   clk  : system clock
//   res  : asynchronous active-high reset
//   bus  : video_render_mx_if.slave (c1 strobe, controls, data in; vplex_out)
// Build option: define RENDER_MX_HIRES_EN to add hi-res nibble packing
// (temp register + hires path); otherwise hires is ignored.
module video_render_mx #(
  parameter int LAYERS     = 2,
  parameter int TRANS_BITS = 4,
  parameter int GPW        = 2
) (
  input  logic                  clk,
  input  logic                  res,
  video_render_mx_if.slave      bus
);

  // ---------------- stage 1: gfx decode ----------------
  logic [15:0] lo;
  logic [3:0]  dot_idx;
  logic        dot;
  logic [7:0]  attr;
  logic        inv;
  logic [3:0]  nib;
  logic [7:0]  pix8;
  logic [7:0]  gfx_pix_d;
  logic        gfx_vld_d;

  always_comb begin
    lo      = bus.data[15:0];
    // ZX bit order is MSB-first within each byte
    dot_idx = {bus.psel[3], ~bus.psel[2:0]};
    dot     = lo[dot_idx];
    attr    = bus.psel[3] ? bus.data[31:24] : bus.data[23:16];
    inv     = dot ^ (bus.flash & attr[7]);
    case (bus.psel[1:0])
      2'd0:    nib = bus.data[7:4];
      2'd1:    nib = bus.data[3:0];
      2'd2:    nib = bus.data[15:12];
      default: nib = bus.data[11:8];
    endcase
    pix8      = bus.psel[0] ? bus.data[15:8] : bus.data[7:0];
    gfx_pix_d = '0;
    gfx_vld_d = 1'b0;
    case (bus.render_mode)
      2'd0: begin
        gfx_pix_d = {bus.palsel, attr[6], inv ? attr[2:0] : attr[5:3]};
        gfx_vld_d = inv;
      end
      2'd1: begin
        gfx_pix_d = {bus.palsel, nib};
        gfx_vld_d = |nib;
      end
      2'd2: begin
        gfx_pix_d = pix8;
        gfx_vld_d = |pix8;
      end
      default: begin
        gfx_pix_d = {bus.palsel, dot ? attr[3:0] : attr[7:4]};
        gfx_vld_d = dot;
      end
    endcase
  end

  logic [7:0]             gfx_pix_q;
  logic                   gfx_vld_q;
  logic [LAYERS-1:0][7:0] ts_q;
  logic [LAYERS-1:0]      tsu_off_q;
  logic [7:0]             border_q;
  logic                   hvpix_q, hvtspix_q, nogfx_q;
  logic [GPW-1:0]         gfx_pos_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      gfx_pix_q <= '0;
      gfx_vld_q <= 1'b0;
      ts_q      <= '0;
      tsu_off_q <= '0;
      border_q  <= '0;
      hvpix_q   <= 1'b0;
      hvtspix_q <= 1'b0;
      nogfx_q   <= 1'b0;
      gfx_pos_q <= '0;
    end else if (bus.c1) begin
      gfx_pix_q <= gfx_pix_d;
      gfx_vld_q <= gfx_vld_d;
      ts_q      <= bus.tsdata_in;
      tsu_off_q <= bus.tsu_off;
      border_q  <= bus.border_in;
      hvpix_q   <= bus.hvpix;
      hvtspix_q <= bus.hvtspix;
      nogfx_q   <= bus.nogfx;
      gfx_pos_q <= bus.gfx_pos;
    end
  end

  // ---------------- stage 2: priority mix ----------------
  logic [LAYERS-1:0] vis;
  logic [7:0]        video;
  logic              found;
  int                gp;

  always_comb begin
    for (int k = 0; k < LAYERS; k++)
      vis[k] = (ts_q[k][TRANS_BITS-1:0] != '0) && !tsu_off_q[k];
  end

  always_comb begin
    video = border_q;
    found = 1'b0;
    gp    = (int'(gfx_pos_q) >= LAYERS) ? LAYERS : int'(gfx_pos_q);
    if (hvpix_q) begin
      // gfx is checked just before the layer sitting in its slot
      for (int k = 0; k < LAYERS; k++) begin
        if (!found && k == gp && gfx_vld_q && !nogfx_q) begin
          video = gfx_pix_q;
          found = 1'b1;
        end
        if (!found && vis[k]) begin
          video = ts_q[k];
          found = 1'b1;
        end
      end
      // covers both gfx in the last slot and the transparent-paper fallback
      if (!found && !nogfx_q) video = gfx_pix_q;
    end else if (hvtspix_q) begin
      for (int k = 0; k < LAYERS; k++) begin
        if (!found && vis[k]) begin
          video = ts_q[k];
          found = 1'b1;
        end
      end
    end
  end

  logic [7:0] vplex_q;
  assign bus.vplex_out = vplex_q;

`ifdef RENDER_MX_HIRES_EN
  logic       hires_q;
  logic [3:0] temp;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hires_q <= 1'b0;
      temp    <= '0;
      vplex_q <= '0;
    end else if (bus.c1) begin
      hires_q <= bus.hires;
      temp    <= video[3:0];
      // hires pairs the previous pixel's low nibble with the current one
      vplex_q <= hires_q ? {temp, video[3:0]} : video;
    end
  end
`else
  logic unused_hires;
  assign unused_hires = bus.hires;

  always_ff @(posedge clk or posedge res) begin
    if (res)         vplex_q <= '0;
    else if (bus.c1) vplex_q <= video;
  end
`endif

endmodule
